uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte buffer and launch controller placed directly upstream of `uart_tx`. Bus-side logic pushes bytes at full clock rate. The block stores them in a DEPTH-entry FIFO and hands them to `uart_tx` one at a time, issuing each `send_sig` only after the previous frame's `tx_done`. It decouples system-bus write bursts from the serial bit rate (87 clks/bit at 10 MHz / 115200).

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `CNT_W`, $clog2(DEPTH)+1, width of `count`; derived, not overridden.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  push strobe; `wr_data` is sampled on the `clk` edge when high.
- `wr_data`  in  8  byte to enqueue.
- `full`  out  1  FIFO holds DEPTH bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  CNT_W  bytes stored, excluding any byte already launched.
- `overflow`  out  1  one-cycle pulse: push attempted while `full`; the byte is dropped.
- `send_sig`  out  1  one-cycle launch pulse to `uart_tx`.
- `tx_data`  out  8  byte to `uart_tx.data`; held stable from launch until `tx_done`.
- `tx_busy`  in  1  from `uart_tx`; a launch is inhibited while high.
- `tx_done`  in  1  from `uart_tx`; one-cycle pulse at the end of the stop bit.

## Operation
- Storage is a circular buffer with CNT_W-bit read and write pointers.
  - Address = low bits of the pointer.
  - `empty` = pointers equal.
  - `full` = MSBs differ and low bits equal.
  - Pointers wrap naturally modulo 2·DEPTH.
- Push: when `wr_en` is high and `full` is low, write `mem[wr_ptr]` and increment `wr_ptr`.
- Push when full: when `wr_en` is high and `full` is high, nothing is written and `overflow` is high in the next cycle.
  - `full` is evaluated before the edge, so a push while full is dropped even if a pop occurs on the same edge.
- Pop: this is the FSM launch; it increments `rd_ptr` and loads `tx_data <= mem[rd_ptr]`.
- Push and pop on the same edge while not full: both take effect and `count` is unchanged.
- No write-to-launch bypass: a byte pushed into an empty FIFO is launched no earlier than the following cycle.
- FSM states:
  - IDLE: if `!empty && !tx_busy`, pop, set `send_sig` to 1, and go to LAUNCH; otherwise stay.
  - LAUNCH: `send_sig` returns to 0; go to WAIT.
  - WAIT: on `tx_done`, go to IDLE; otherwise stay. `tx_busy` is ignored here.
- `tx_done` seen in IDLE or LAUNCH is ignored.
- `tx_data` changes only on a pop; it keeps its last value while idle.
- Reset (asynchronous, active-low), whether idle or mid-frame:
  - Pointers = 0, state = IDLE, FIFO contents are discarded.
  - Outputs: `send_sig`=0, `tx_data`=8'h00, `overflow`=0, `empty`=1, `full`=0, `count`=0.
  - `uart_tx` shares `reset`, so no half-frame is resumed.
- `count` = `wr_ptr - rd_ptr`, computed modulo 2^CNT_W; range is 0..DEPTH.

## Timing
- All outputs are registered or decoded directly from registers; there is no combinational path from inputs to outputs.
- A push on edge E updates `count`, `empty` and `full` after E.
- Empty FIFO, IDLE, `tx_busy`=0, push on edge E: the pop happens on E+1, `send_sig`=1 during the cycle after E+1, and `tx_data` is valid in that same cycle.
- Launch spacing: `tx_done` sampled on edge D → IDLE after D → next pop on D+1. Minimum gap is therefore two clocks from `tx_done` to the next `send_sig`.
- `overflow` is high exactly one cycle per dropped push.

## Structure
- Shared package `uart_pkg`:
  - `UART_BYTE_W` = 8.
  - FSM state encoding: IDLE, LAUNCH, WAIT.
  - Shared by `uart_rx`, `uart_tx` and this block.
- Sub-module `sync_fifo`: parameterised width/depth storage plus pointers, with `full`/`empty`/`count`/`overflow`. `uart_tx_fifo` adds the launch FSM and the `tx_data` register. Later reused on the RX side.

## Test plan
- Reset: hold `reset`=0 mid-run, then release → `empty`=1, `full`=0, `count`=0, `send_sig`=0, `tx_data`=8'h00, `overflow`=0.
- Single byte: push 8'hAB into an idle FIFO → `send_sig` pulses exactly once, two clocks after the push edge, with `tx_data`=8'hAB. `count` goes 1→0. The serial line decodes 8'hAB, with no further `send_sig` after `tx_done`.
- Ordering: push 8'h11, 8'h22, 8'h33 back-to-back → three frames in that order. Each `send_sig` comes two clocks after the preceding `tx_done`, and `tx_data` is stable throughout each frame.
- Full/overflow: hold `tx_busy`=1 and push 16 bytes 8'h00..8'h0F → `full`=1, `count`=16. A 17th push of 8'hEE pulses `overflow` once. After `tx_busy` is released, exactly 8'h00..8'h0F are transmitted and 8'hEE never is.
- Wrap-around: stream 40 incrementing bytes with pushes interleaved against pops, including a simultaneous push+pop edge → all 40 bytes are sent in order and `count` never exceeds 16.
- Reset mid-frame: assert `reset` during WAIT with 5 bytes queued → after release, `count`=0 and the state is IDLE. A subsequent push of 8'h5A is the next byte transmitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the TX launch FSM encoding.
// Used by uart_rx, uart_tx and uart_tx_fifo.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with extra-MSB pointers.
// Drops pushes while full and flags them with a one-cycle overflow.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_BYTE_W,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int AW    = CNT_W - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      overflow <= wr_en && full;
    end
  end

  // Contents need no reset: pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch FSM feeding uart_tx one frame at a time.
// Next launch waits for the previous frame's tx_done.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       count,
  output logic                   overflow,
  output logic                   send_sig,
  output logic [UART_BYTE_W-1:0] tx_data,
  input  logic                   tx_busy,
  input  logic                   tx_done
);

  tx_state_e              state;
  tx_state_e              nxt;
  logic                   pop;
  logic [UART_BYTE_W-1:0] fifo_q;

  sync_fifo #(
    .WIDTH (UART_BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_q),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    pop = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop = 1'b1;
          nxt = LAUNCH;
        end
      end
      LAUNCH: nxt = WAIT;
      WAIT: begin
        if (tx_done) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // LAUNCH lasts exactly one cycle, so the pulse is a state decode.
  assign send_sig = (state == LAUNCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   tx_data <= '0;
    else if (pop) tx_data <= fifo_q;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural uart_tx model.
// Expected bytes queue on push and are consumed on each launch.
module tb_uart_tx_fifo;

  localparam int FRAME = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       send_sig;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  logic       model_busy;
  logic       hold_busy;
  assign tx_busy = model_busy || hold_busy;

  uart_tx_fifo #(.DEPTH(16)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .send_sig (send_sig),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] sb [$];

  bit         in_frame   = 0;
  int         frame_left = 0;
  logic [7:0] frame_byte = '0;
  bit         stable_bad = 0;
  bit         chk_gap    = 0;
  bit         done_valid = 0;
  int         done_at    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  // Behavioural uart_tx: busy for FRAME cycles, then tx_done pulse
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame   = 0;
        model_busy = 0;
        tx_done    = 0;
      end else begin
        if (tx_done) begin
          tx_done    = 0;
          model_busy = 0;
        end
        if (in_frame) begin
          if (frame_left == FRAME)
            chk("send_pulse_width", send_sig, 0);
          if (tx_data !== frame_byte) stable_bad = 1;
          frame_left--;
          if (frame_left == 0) begin
            chk("tx_data_stable", stable_bad, 0);
            in_frame   = 0;
            tx_done    = 1;
            done_at    = cyc + 1;
            done_valid = 1;
          end
        end else if (send_sig) begin
          chk("send_expected", sb.size() > 0, 1);
          if (sb.size() > 0) chk("tx_data", tx_data, sb.pop_front());
          if (chk_gap && done_valid)
            chk("launch_gap", cyc - done_at, 1);
          in_frame   = 1;
          model_busy = 1;
          frame_left = FRAME;
          frame_byte = tx_data;
          stable_bad = 0;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit drop);
    wr_en   = 1;
    wr_data = b;
    if (!drop) sb.push_back(b);
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic drain(input string tag);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !in_frame && !tx_done) begin
        ok = 1;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_send"}, send_sig, 0);
    chk({tag, "_txdata"}, tx_data, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int maxc;
    int guard;
    rst_n     = 0;
    wr_en     = 0;
    wr_data   = '0;
    hold_busy = 0;
    repeat (2) @(negedge clk);
    chk_reset_outs("rst");
    rst_n = 1;
    @(negedge clk);

    // single byte
    push(8'hAB, 0);
    chk("single_count1", count, 1);
    chk("single_nosend", send_sig, 0);
    @(negedge clk);
    chk("single_send", send_sig, 1);
    chk("single_data", tx_data, 8'hAB);
    chk("single_count0", count, 0);
    drain("single_drain");
    repeat (20) @(negedge clk);

    // ordering with launch spacing
    chk_gap    = 1;
    done_valid = 0;
    push(8'h11, 0);
    push(8'h22, 0);
    push(8'h33, 0);
    drain("order_drain");
    chk_gap = 0;

    // full and overflow
    hold_busy = 1;
    for (int i = 0; i < 16; i++) push(8'(i), 0);
    chk("full_flag", full, 1);
    chk("full_count", count, 16);
    push(8'hEE, 1);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 16);
    @(negedge clk);
    chk("ovf_single", overflow, 0);
    hold_busy = 0;
    drain("full_drain");
    chk("full_empty", empty, 1);

    // wrap-around stream
    n = 0;
    maxc = 0;
    guard = 0;
    while (n < 40 && guard < 4000) begin
      if (!full) begin
        push(8'h40 + 8'(n), 0);
        n++;
        if (n == 2) chk("wrap_pushpop", count, 1);
      end else begin
        @(negedge clk);
      end
      if (int'(count) > maxc) maxc = int'(count);
      guard++;
    end
    chk("wrap_pushed", n, 40);
    drain("wrap_drain");
    chk("wrap_maxcnt", maxc, 16);

    // reset mid-frame
    for (int i = 0; i < 6; i++) push(8'h70 + 8'(i), 0);
    chk("mf_count", count, 5);
    chk("mf_inframe", in_frame, 1);
    rst_n = 0;
    sb.delete();
    @(negedge clk);
    chk_reset_outs("mf_rst");
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("mf_post_count", count, 0);
    chk("mf_post_empty", empty, 1);
    push(8'h5A, 0);
    @(negedge clk);
    chk("mf_send", send_sig, 1);
    chk("mf_data", tx_data, 8'h5A);
    drain("mf_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
